// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions.
//   - message widths: 5-bit sign-magnitude c2v/channel inputs, 6-bit v2c outputs
//   - internal two's-complement width for node sums
//   - magnitude saturation point and the PHI lookup table
//   - sm2tc(): sign-magnitude to two's-complement decode (-0 maps to 0)
package ldpc_pkg;

    localparam int C2V_W   = 5;   // sign + 4-bit magnitude
    localparam int V2C_W   = 6;   // hard + sign + 4-bit phi magnitude
    localparam int MAG_W   = 4;
    localparam int TC_W    = 8;   // holds +/-105 totals and +/-120 extrinsics
    localparam int MAG_SAT = 15;

    localparam logic [MAG_W-1:0] PHI_TABLE [16] = '{
        4'd15, 4'd12, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3,
        4'd3,  4'd2,  4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1
    };

    function automatic logic signed [TC_W-1:0] sm2tc(input logic [C2V_W-1:0] x);
        logic signed [TC_W-1:0] m;
        m = {{(TC_W-MAG_W){1'b0}}, x[MAG_W-1:0]};
        return x[C2V_W-1] ? -m : m;
    endfunction

endpackage

// File: rtl/vnu_if.sv
// Variable-node message interface.
//   master (decoder control / bench): ch_load, ch_llr, in_valid, init, c2v[DEG]
//   slave  (vnu):                     out_valid, v2c[DEG], hard_bit
interface vnu_if
    import ldpc_pkg::*;
#(
    parameter int DEG = 3
);
    logic                           ch_load;
    logic [C2V_W-1:0]               ch_llr;
    logic                           in_valid;
    logic                           init;
    logic [DEG-1:0][C2V_W-1:0]      c2v;
    logic                           out_valid;
    logic [DEG-1:0][V2C_W-1:0]      v2c;
    logic                           hard_bit;

    modport master (
        output ch_load, ch_llr, in_valid, init, c2v,
        input  out_valid, v2c, hard_bit
    );

    modport slave (
        input  ch_load, ch_llr, in_valid, init, c2v,
        output out_valid, v2c, hard_bit
    );
endinterface

// File: rtl/vnu_phi_lut.sv
// PHI magnitude transform, purely combinational.
//   idx : saturated extrinsic magnitude (0..15)
//   phi : PHI_TABLE[idx]
module vnu_phi_lut
    import ldpc_pkg::*;
(
    input  logic [MAG_W-1:0] idx,
    output logic [MAG_W-1:0] phi
);
    assign phi = PHI_TABLE[idx];
endmodule

// File: rtl/vnu.sv
// LDPC variable-node update, 2-stage pipeline, one message set per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vnu_if slave -- channel load, c2v inputs, v2c / hard_bit outputs
// Stage 1 registers the node total (channel + all c2v) and the decoded c2v
// copies; stage 2 forms per-edge extrinsics, saturates, maps through PHI and
// registers the outputs. Output registers hold between valid results.
module vnu
    import ldpc_pkg::*;
#(
    parameter int DEG = 3
)(
    input  logic  clk,
    input  logic  rst,
    vnu_if.slave  bus
);
    localparam int STAGES = 2;

    logic [C2V_W-1:0]           ch_q;
    logic [C2V_W-1:0]           ch_eff;
    logic [STAGES:1]            vld_pipe;

    logic signed [TC_W-1:0]     c2v_d [DEG];
    logic signed [TC_W-1:0]     total_d;
    logic signed [TC_W-1:0]     c2v_q [DEG];
    logic signed [TC_W-1:0]     total_q;

    logic signed [TC_W-1:0]     ext   [DEG];
    logic signed [TC_W-1:0]     ext_a [DEG];
    logic [DEG-1:0][MAG_W-1:0]  mag_sat;
    logic [DEG-1:0][MAG_W-1:0]  phi_mag;

    logic [DEG-1:0][V2C_W-1:0]  v2c_q;
    logic                       hard_q;

    // A load in the same cycle as a message set feeds stage 1 directly.
    assign ch_eff = bus.ch_load ? bus.ch_llr : ch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ch_q <= '0;
        else if (bus.ch_load)
            ch_q <= bus.ch_llr;
    end

    // Stage 1 combinational: decode and sum. init forces all c2v to zero.
    always_comb begin
        total_d = sm2tc(ch_eff);
        for (int i = 0; i < DEG; i++) begin
            c2v_d[i] = bus.init ? '0 : sm2tc(bus.c2v[i]);
            total_d  = total_d + c2v_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
            for (int i = 0; i < DEG; i++) c2v_q[i] <= '0;
        end else if (bus.in_valid) begin
            total_q <= total_d;
            for (int i = 0; i < DEG; i++) c2v_q[i] <= c2v_d[i];
        end
    end

    // Stage 2 combinational: extrinsic = total minus own edge; |total| <= 105
    // keeps every difference inside 8 bits, so no overflow handling is needed.
    always_comb begin
        for (int i = 0; i < DEG; i++) begin
            ext[i]     = total_q - c2v_q[i];
            ext_a[i]   = ext[i][TC_W-1] ? -ext[i] : ext[i];
            mag_sat[i] = (ext_a[i] > 8'sd15) ? MAG_W'(MAG_SAT) : ext_a[i][MAG_W-1:0];
        end
    end

    vnu_phi_lut u_phi [DEG-1:0] (
        .idx (mag_sat),
        .phi (phi_mag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            v2c_q    <= '0;
            hard_q   <= 1'b0;
        end else begin
            vld_pipe[1] <= bus.in_valid;
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                hard_q <= total_q[TC_W-1];
                for (int i = 0; i < DEG; i++)
                    v2c_q[i] <= {total_q[TC_W-1], ext[i][TC_W-1], phi_mag[i]};
            end
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.v2c       = v2c_q;
    assign bus.hard_bit  = hard_q;

endmodule

// File: tb/tb_vnu.sv
module tb_vnu;
    localparam int DEG = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vnu_if #(.DEG(DEG)) bus ();
    vnu #(.DEG(DEG)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0]          due;
        logic [DEG-1:0][5:0]  v2c;
        logic                 hard;
    } exp_t;

    typedef struct {
        logic [4:0] ch;
        logic [4:0] c2v [DEG];
        logic       init;
        logic [5:0] v2c [DEG];
        logic       hard;
    } vec_t;

    int   phi_ref [16] = '{15, 12, 9, 7, 6, 5, 4, 3, 3, 2, 2, 2, 1, 1, 1, 1};
    exp_t q [$];
    exp_t last;
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    logic [4:0] m_ch;
    vec_t tv [4];

    function automatic int smv(logic [4:0] x);
        return x[4] ? -int'(x[3:0]) : int'(x[3:0]);
    endfunction

    // Reference: integer arithmetic straight from the node equations.
    function automatic exp_t model(logic [4:0] ch, logic [DEG-1:0][4:0] c, logic ini);
        exp_t r;
        int total, ev, m;
        r = '0;
        total = smv(ch);
        for (int i = 0; i < DEG; i++) if (!ini) total += smv(c[i]);
        for (int i = 0; i < DEG; i++) begin
            ev = total - (ini ? 0 : smv(c[i]));
            m  = (ev < 0) ? -ev : ev;
            if (m > 15) m = 15;
            r.v2c[i] = {(total < 0), (ev < 0), 4'(phi_ref[m])};
        end
        r.hard = (total < 0);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic check_out();
        logic exp_v;
        exp_v = (q.size() > 0) && (q[0].due == edge_n);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) last = q.pop_front();
        chk("v2c", 32'(bus.v2c), 32'(last.v2c));
        chk("hard_bit", 32'(bus.hard_bit), 32'(last.hard));
    endtask

    task automatic tick(input exp_t ex);
        if (bus.in_valid && !rst) begin
            ex.due = edge_n + 2;
            q.push_back(ex);
        end
        if (bus.ch_load && !rst) m_ch = bus.ch_llr;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        check_out();
    endtask

    task automatic drive(input logic ld, input logic [4:0] ch, input logic iv,
                         input logic ini, input logic [DEG-1:0][4:0] c);
        bus.ch_load  = ld;
        bus.ch_llr   = ch;
        bus.in_valid = iv;
        bus.init     = ini;
        bus.c2v      = c;
    endtask

    task automatic step_model();
        tick(model(bus.ch_load ? bus.ch_llr : m_ch, bus.c2v, bus.init));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 5'd0, 1'b0, 1'b0, '0);
            step_model();
        end
    endtask

    task automatic check_zero(string name);
        chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_v2c"}, 32'(bus.v2c), 32'd0);
        chk({name, "_hard"}, 32'(bus.hard_bit), 32'd0);
    endtask

    initial begin
        logic [DEG-1:0][4:0] c;

        // vectors: ch, c2v[0..2], init, expected v2c[0..2], hard
        tv[0].ch = 5'b00101; tv[0].c2v = '{5'b01111, 5'b11010, 5'b00111}; tv[0].init = 1'b1;
        tv[0].v2c = '{6'b000101, 6'b000101, 6'b000101}; tv[0].hard = 1'b0;
        tv[1].ch = 5'b00011; tv[1].c2v = '{5'b00100, 5'b10010, 5'b00110}; tv[1].init = 1'b0;
        tv[1].v2c = '{6'b000011, 6'b000001, 6'b000101}; tv[1].hard = 1'b0;
        tv[2].ch = 5'b11111; tv[2].c2v = '{5'b11111, 5'b11111, 5'b11111}; tv[2].init = 1'b0;
        tv[2].v2c = '{6'b110001, 6'b110001, 6'b110001}; tv[2].hard = 1'b1;
        tv[3].ch = 5'b00010; tv[3].c2v = '{5'b10010, 5'b10000, 5'b00000}; tv[3].init = 1'b0;
        tv[3].v2c = '{6'b001001, 6'b001111, 6'b001111}; tv[3].hard = 1'b0;

        // Reset: outputs clear immediately
        rst = 1'b1;
        m_ch = '0;
        last = '0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, '0);
        #1;
        check_zero("reset");
        idle(2);
        rst = 1'b0;
        idle(2);

        // Directed vectors
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < DEG; i++) c[i] = tv[t].c2v[i];
            drive(1'b1, tv[t].ch, 1'b1, tv[t].init, c);
            e = '0;
            for (int i = 0; i < DEG; i++) e.v2c[i] = tv[t].v2c[i];
            e.hard = tv[t].hard;
            tick(e);
            idle(3);
        end

        // Streaming: 8 back-to-back sets, channel reloaded every other cycle
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < DEG; i++) c[i] = 5'($urandom_range(0, 31));
            drive((k % 2) == 0, 5'($urandom_range(0, 31)), 1'b1, 1'b0, c);
            step_model();
        end
        idle(3);

        // Reset one cycle after a message set is accepted: it must vanish
        for (int i = 0; i < DEG; i++) c[i] = 5'($urandom_range(0, 31));
        drive(1'b1, 5'b01001, 1'b1, 1'b0, c);
        step_model();
        drive(1'b0, 5'd0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        #1;
        q.delete();
        last = '0;
        m_ch = '0;
        check_zero("midreset");
        idle(2);
        rst = 1'b0;
        // First set after reset, no load: uses the cleared channel register
        for (int i = 0; i < DEG; i++) c[i] = 5'($urandom_range(0, 31));
        drive(1'b0, 5'b01111, 1'b1, 1'b0, c);
        step_model();
        idle(3);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < DEG; i++) c[i] = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, c);
            step_model();
        end
        idle(3);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
